// File: rtl/xpb_accum.sv
// xpb_accum: table-lookup accumulator that sums one table entry per operand digit
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (table storage is not reset)
//   wr_en     table write strobe, honoured only while idle
//   wr_addr   table address {bank, digit}
//   wr_data   table write data
//   wr_err    one-cycle pulse when a write arrives while busy and is dropped
//   in_valid  operand valid
//   in_ready  high while idle
//   in_data   operand, digit s at in_data[s*SEG_BITS +: SEG_BITS]
//   out_valid result valid, held until out_ready
//   out_ready consumer accepts result
//   out_data  full-width sum of the selected entries (zero digits contribute 0)
module xpb_accum #(
  parameter int SEG_BITS  = 5,
  parameter int NUM_SEGS  = 4,
  parameter int WORD_BITS = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [$clog2(NUM_SEGS)+SEG_BITS-1:0]   wr_addr,
  input  logic [WORD_BITS-1:0]                   wr_data,
  output logic                                   wr_err,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_SEGS*SEG_BITS-1:0]           in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_BITS+$clog2(NUM_SEGS)-1:0]  out_data
);
  localparam int BB = $clog2(NUM_SEGS);
  localparam int AW = BB + SEG_BITS;
  localparam int DW = NUM_SEGS * SEG_BITS;
  localparam int OW = WORD_BITS + BB;
  localparam int CW = $clog2(NUM_SEGS + 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [DW-1:0]        in_q;
  logic [OW-1:0]        acc_q;
  logic                 wr_err_q;
  logic                 old_v_q;
  logic [AW-1:0]        old_addr_q;
  logic [WORD_BITS-1:0] old_q;
  logic [WORD_BITS-1:0] rd_q;
  logic [WORD_BITS-1:0] mem_q [2**AW];
  logic                 accept;
  logic                 wr_ok;
  logic [AW-1:0]        rd_addr;
  assign accept    = in_valid && state_q == IDLE;
  assign wr_ok     = wr_en && state_q == IDLE;
  assign rd_addr   = {cnt_q[BB-1:0], in_q[SEG_BITS-1:0]};
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data  = acc_q;
  assign wr_err    = wr_err_q;
  // RUN spans NUM_SEGS reads plus one trailing accumulate and one settle cycle
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? RUN : IDLE)
            : state_q == RUN  ? (cnt_q == CW'(NUM_SEGS + 1) ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_q     <= '0;
      acc_q    <= '0;
      wr_err_q <= 1'b0;
      old_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_en && state_q != IDLE;
      if (accept) begin
        cnt_q   <= '0;
        in_q    <= in_data;
        acc_q   <= '0;
        old_v_q <= wr_ok;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CW'(1);
        in_q  <= in_q >> SEG_BITS;
        if (cnt_q != '0 && cnt_q <= CW'(NUM_SEGS))
          acc_q <= acc_q + OW'(rd_q);
      end
    end
  end
  // A write landing on the accept edge must stay invisible to that operand,
  // so the overwritten entry is captured and substituted on a matching read.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wr_addr] <= wr_data;
    if (accept) begin
      old_addr_q <= wr_addr;
      old_q      <= mem_q[wr_addr];
    end
    rd_q <= in_q[SEG_BITS-1:0] == '0 ? '0
          : (old_v_q && rd_addr == old_addr_q) ? old_q
          : mem_q[rd_addr];
  end
endmodule

// File: doc/xpb_accum.md
XPB_ACCUM -- requirements
Module: xpb_accum

Interface
REQ-001 SHALL have parameter SEG_BITS, default 5, meaning bits per lookup digit.
REQ-002 SHALL have parameter NUM_SEGS, default 4, meaning number of digits and table banks per operation.
REQ-003 SHALL have parameter WORD_BITS, default 1024, meaning width of each table entry.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  table write strobe.
REQ-007 SHALL have port wr_addr  input  clog2(NUM_SEGS)+SEG_BITS  table address {bank, digit}.
REQ-008 SHALL have port wr_data  input  WORD_BITS  table write data.
REQ-009 SHALL have port wr_err  output  1  one-cycle pulse when a write is dropped.
REQ-010 SHALL have port in_valid  input  1  operand valid.
REQ-011 SHALL have port in_ready  output  1  block can accept an operand.
REQ-012 SHALL have port in_data  input  NUM_SEGS*SEG_BITS  operand; digit s = in_data[s*SEG_BITS +: SEG_BITS].
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_data  output  WORD_BITS+clog2(NUM_SEGS)  accumulated sum.

Function
REQ-016 SHALL hold a table of NUM_SEGS banks x 2^SEG_BITS entries x WORD_BITS bits, written only through wr_*.
REQ-017 SHALL compute out_data = sum over s of (digit_s==0 ? 0 : table[s][digit_s]), unsigned, with no truncation.
REQ-018 SHALL treat a zero digit as contributing 0 regardless of table contents.
REQ-019 SHALL implement FSM states IDLE, RUN, DONE.
REQ-020 SHALL drive in_ready high only in IDLE.
REQ-021 SHALL accept an operand on an edge where in_valid && in_ready, latch in_data, clear the accumulator, and go IDLE->RUN.
REQ-022 SHALL in RUN issue one registered table read per cycle, segment 0 first, and add each read result into the accumulator one cycle after it is read.
REQ-023 SHALL go RUN->DONE after the last accumulation, with out_valid rising exactly NUM_SEGS+2 cycles after the accept edge.
REQ-024 SHALL in DONE hold out_valid high and out_data stable until an edge with out_ready high, then go DONE->IDLE.
REQ-025 SHALL drive in_ready low in the handshake cycle, so the earliest next accept is the cycle after a DONE->IDLE transition.
REQ-026 SHALL perform a write only when wr_en is high and the state is IDLE; the write takes effect on that edge and is readable by an operand accepted on the next edge.
REQ-027 SHALL drop wr_en asserted in RUN or DONE, leave the table unchanged, and pulse wr_err high for one cycle.
REQ-028 SHALL not mask an operand accept when wr_en and in_valid arrive together in IDLE; both take effect, and the accepted operand sees the old entry at the written address.
REQ-029 SHALL be reset-free in the table storage, with contents undefined until written.

Reset
REQ-030 SHALL, while reset is high, immediately force state IDLE, out_valid 0, out_data 0, wr_err 0, accumulator 0, and segment counter 0.
REQ-031 SHALL drive in_ready 1 from the first edge after reset deasserts.
REQ-032 SHALL, when reset occurs mid-operation, abandon the operation with no result emitted and leave table contents intact.

Verification (test configuration WORD_BITS=16, SEG_BITS=5, NUM_SEGS=4; table[s][d] = 16'h0100*s + d unless stated)
REQ-033 SHALL cover basic operation: in_data=20'hF8C41 (digits 1,2,3,31), out_ready=1 -> out_valid on cycle 6 after accept, out_data=18'h00625.
REQ-034 SHALL cover zero-digit masking: table[s][0]=16'hFFFF for all s, in_data=0 -> out_data=18'h00000.
REQ-035 SHALL cover width growth: all entries 16'hFFFF, in_data=20'hFFFFF -> out_data=18'h3FFFC.
REQ-036 SHALL cover backpressure: out_ready low for 10 cycles after out_valid -> out_data stays 18'h00625, in_ready stays 0; after release, in_ready is 1 on the following cycle.
REQ-037 SHALL cover dropped writes: wr_en during RUN to addr {0,1} with 16'hDEAD -> wr_err pulses one cycle, and the next op with digit0=1 still uses 16'h0001.
REQ-038 SHALL cover reset mid-operation: reset asserted 2 cycles after accept -> out_valid 0 and no result; after release, REQ-033 stimulus returns 18'h00625.
